// File: rtl/seg_scroll_pkg.sv
// Shared definitions for the seven-segment marquee: scroller state encoding and digit codes
// understood by the downstream glyph decoder.
package seg_scroll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } scroll_state_t;

  localparam logic [3:0] DIG_BLANK = 4'hd;
  localparam logic [3:0] DIG_U     = 4'hc;
  localparam logic [3:0] DIG_B     = 4'hb;
  localparam logic [3:0] DIG_F     = 4'hf;

endpackage

// File: rtl/seg_msg_buf.sv
// Message store: DEPTH x CODE_W register file, one synchronous write port and one async read port.
// A read of an entry being written in the same cycle returns the old contents.
module seg_msg_buf #(
  parameter int DEPTH  = 16,
  parameter int CODE_W = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [CODE_W-1:0] rd_data
);

  logic [CODE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/seg_msg_scroller.sv
// Marquee engine: scrolls a buffered message across NUM_DIGITS seven-segment slots, one slot per step.
// Outputs update on the clk edge that samples step; no backpressure, run=0 freezes everything.
module seg_msg_scroller
  import seg_scroll_pkg::*;
#(
  parameter int                NUM_DIGITS = 6,
  parameter int                CODE_W     = 4,
  parameter int                MSG_DEPTH  = 16,
  parameter logic [CODE_W-1:0] BLANK_CODE = CODE_W'(DIG_BLANK)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           step,
  input  logic                           run,
  input  logic                           oneshot,
  input  logic                           dir,
  input  logic [$clog2(MSG_DEPTH):0]     msg_len,
  input  logic                           restart,
  input  logic                           wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr,
  input  logic [CODE_W-1:0]              wr_data,
  output logic [NUM_DIGITS*CODE_W-1:0]   display,
  output logic [$clog2(MSG_DEPTH)-1:0]   pos,
  output logic                           busy,
  output logic                           done
);

  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = $clog2(NUM_DIGITS + 1);
  localparam int DW = NUM_DIGITS * CODE_W;

  localparam logic [DW-1:0] ALL_BLANK = {NUM_DIGITS{BLANK_CODE}};
  localparam logic [FW-1:0] FLUSH_LAST = FW'(NUM_DIGITS - 1);

  scroll_state_t     state_q, state_d;
  logic [AW-1:0]     pos_q, pos_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              done_q, done_d;
  logic              armed_q, armed_d;

  logic [LW-1:0]     eff_len;
  logic              past_end;
  logic [AW-1:0]     rd_addr;
  logic [CODE_W-1:0] rd_data;
  logic              rd_last;
  logic              adv;

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] cur,
                                             input logic [CODE_W-1:0] code,
                                             input logic right);
    if (right) begin
      return (cur >> CODE_W) | (DW'(code) << (DW - CODE_W));
    end
    return (cur << CODE_W) | DW'(code);
  endfunction

  seg_msg_buf #(
    .DEPTH  (MSG_DEPTH),
    .CODE_W (CODE_W),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign eff_len  = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
  assign past_end = ({1'b0, pos_q} >= eff_len);
  // A shrunken message wraps the read back to entry 0 before it is shifted in.
  assign rd_addr  = past_end ? '0 : pos_q;
  assign rd_last  = ({1'b0, rd_addr} == (eff_len - LW'(1)));
  assign adv      = step && run;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    disp_d  = disp_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    armed_d = armed_q;

    if (restart) begin
      disp_d = ALL_BLANK;
      pos_d  = '0;
      fcnt_d = '0;
      if (run && (eff_len != '0)) begin
        state_d = ST_SCROLL;
        armed_d = 1'b0;
      end else begin
        state_d = ST_IDLE;
        armed_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q && run && (eff_len != '0)) begin
            state_d = ST_SCROLL;
            armed_d = 1'b0;
          end
        end

        ST_SCROLL: begin
          if (eff_len == '0) begin
            state_d = ST_IDLE;
          end else if (adv) begin
            if (past_end && oneshot) begin
              pos_d   = '0;
              fcnt_d  = '0;
              state_d = ST_FLUSH;
            end else begin
              disp_d = shift_in(disp_q, rd_data, dir);
              if (rd_last) begin
                pos_d = '0;
                if (oneshot) begin
                  fcnt_d  = '0;
                  state_d = ST_FLUSH;
                end
              end else begin
                pos_d = rd_addr + AW'(1);
              end
            end
          end
        end

        ST_FLUSH: begin
          if (adv) begin
            disp_d = shift_in(disp_q, BLANK_CODE, dir);
            if (fcnt_q == FLUSH_LAST) begin
              fcnt_d  = '0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              fcnt_d = fcnt_q + FW'(1);
            end
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      disp_q  <= ALL_BLANK;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      disp_q  <= disp_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
      armed_q <= armed_d;
    end
  end

  assign display = disp_q;
  assign pos     = pos_q;
  assign busy    = (state_q == ST_SCROLL) || (state_q == ST_FLUSH);
  assign done    = done_q;

endmodule

// File: tb/tb_seg_msg_scroller.sv
// Directed bench for seg_msg_scroller: one record per clock of inputs and expected registered outputs.
module tb_seg_msg_scroller;

  logic        clk = 1'b0;
  logic        rst;
  logic        step, run, oneshot, dir, restart, wr_en;
  logic [4:0]  msg_len;
  logic [3:0]  wr_addr, wr_data;
  logic [23:0] display;
  logic [3:0]  pos;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        run;
    logic        step;
    logic        restart;
    logic [4:0]  len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [23:0] exp_disp;
    logic [3:0]  exp_pos;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  seg_msg_scroller dut (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .run     (run),
    .oneshot (oneshot),
    .dir     (dir),
    .msg_len (msg_len),
    .restart (restart),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .display (display),
    .pos     (pos),
    .busy    (busy),
    .done    (done)
  );

  function automatic vec_t mk(input logic r, input logic s, input logic rs, input logic [4:0] l,
                              input logic we, input logic [3:0] wa, input logic [3:0] wd,
                              input logic [23:0] ed, input logic [3:0] ep, input logic eb,
                              input logic edn);
    vec_t v;
    v.run = r; v.step = s; v.restart = rs; v.len = l;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.exp_disp = ed; v.exp_pos = ep; v.exp_busy = eb; v.exp_done = edn;
    return v;
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    run = v.run; step = v.step; restart = v.restart; msg_len = v.len;
    wr_en = v.wr_en; wr_addr = v.wr_addr; wr_data = v.wr_data;
    @(posedge clk);
    #1;
    check({name, ".display"}, display, v.exp_disp);
    check({name, ".pos"}, 24'(pos), 24'(v.exp_pos));
    check({name, ".busy"}, 24'(busy), 24'(v.exp_busy));
    check({name, ".done"}, 24'(done), 24'(v.exp_done));
  endtask

  initial begin
    logic [3:0]  msg8 [8];
    logic [23:0] exp2 [9];
    logic [23:0] exp3 [6];

    msg8 = '{4'h6, 4'h0, 4'hd, 4'hb, 4'hc, 4'hf, 4'hf, 4'h5};
    exp2 = '{24'hddddd6, 24'hdddd60, 24'hddd60d, 24'hdd60db, 24'hd60dbc,
             24'h60dbcf, 24'h0dbcff, 24'hdbcff5, 24'hbcff56};
    exp3 = '{24'hdd123d, 24'hd123dd, 24'h123ddd, 24'h23dddd, 24'h3ddddd, 24'hdddddd};

    // Idle with an empty message: steps must not disturb the blank display.
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 24'hdddddd, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 0, 1, 4'(i), msg8[i], 24'hdddddd, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8, 0, 0, 0, 24'hdddddd, 0, 1, 0));
    for (int k = 0; k < 9; k++) begin
      tbl.push_back(mk(1, 1, 0, 8, 0, 0, 0, exp2[k], 4'((k + 1) % 8), 1, 0));
      if (k == 2) tbl.push_back(mk(1, 0, 0, 8, 0, 0, 0, exp2[k], 4'(3), 1, 0));
    end

    rst = 1'b1; step = 0; run = 0; oneshot = 0; dir = 0; restart = 0;
    wr_en = 0; msg_len = 0; wr_addr = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.display", display, 24'hdddddd);
    check("reset.pos", 24'(pos), 24'd0);
    check("reset.busy", 24'(busy), 24'd0);
    check("reset.done", 24'(done), 24'd0);
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Freeze with run=0, then restart colliding with a step.
    for (int i = 0; i < 5; i++) apply(mk(0, 1, 0, 8, 0, 0, 0, 24'hbcff56, 1, 1, 0), "freeze");
    apply(mk(0, 1, 1, 8, 0, 0, 0, 24'hdddddd, 0, 0, 0), "restart_step");
    apply(mk(0, 1, 0, 8, 0, 0, 0, 24'hdddddd, 0, 0, 0), "idle_step");
    apply(mk(1, 0, 0, 8, 0, 0, 0, 24'hdddddd, 0, 1, 0), "rearm");
    apply(mk(1, 1, 0, 8, 0, 0, 0, 24'hddddd6, 1, 1, 0), "resume");

    // Write to the entry being shifted in: old value now, new value next pass.
    apply(mk(1, 0, 0, 8, 1, 0, 1, 24'hddddd6, 1, 1, 0), "wr0");
    apply(mk(1, 0, 0, 8, 1, 1, 2, 24'hddddd6, 1, 1, 0), "wr1");
    apply(mk(1, 0, 1, 2, 0, 0, 0, 24'hdddddd, 0, 1, 0), "restart2");
    apply(mk(1, 1, 0, 2, 1, 0, 7, 24'hddddd1, 1, 1, 0), "wr_collide");
    apply(mk(1, 1, 0, 2, 0, 0, 0, 24'hdddd12, 0, 1, 0), "loop_b");
    apply(mk(1, 1, 0, 2, 0, 0, 0, 24'hddd127, 1, 1, 0), "loop_new");

    // One-shot pass of {1,2,3} and its flush.
    oneshot = 1'b1;
    apply(mk(1, 0, 0, 2, 1, 0, 1, 24'hddd127, 1, 1, 0), "os_wr0");
    apply(mk(1, 0, 0, 2, 1, 1, 2, 24'hddd127, 1, 1, 0), "os_wr1");
    apply(mk(1, 0, 0, 2, 1, 2, 3, 24'hddd127, 1, 1, 0), "os_wr2");
    apply(mk(1, 0, 1, 3, 0, 0, 0, 24'hdddddd, 0, 1, 0), "os_restart");
    apply(mk(1, 1, 0, 3, 0, 0, 0, 24'hddddd1, 1, 1, 0), "os_s1");
    apply(mk(1, 1, 0, 3, 0, 0, 0, 24'hdddd12, 2, 1, 0), "os_s2");
    apply(mk(1, 1, 0, 3, 0, 0, 0, 24'hddd123, 0, 1, 0), "os_s3");
    for (int k = 0; k < 6; k++)
      apply(mk(1, 1, 0, 3, 0, 0, 0, exp3[k], 0, (k != 5), (k == 5)), $sformatf("flush[%0d]", k));
    apply(mk(1, 0, 0, 3, 0, 0, 0, 24'hdddddd, 0, 0, 0), "done_drop");
    apply(mk(1, 1, 0, 3, 0, 0, 0, 24'hdddddd, 0, 0, 0), "done_step0");
    apply(mk(1, 1, 0, 3, 0, 0, 0, 24'hdddddd, 0, 0, 0), "done_step1");

    // Right scroll, then msg_len=0 mid-scroll drops to idle without re-arming.
    oneshot = 1'b0;
    dir = 1'b1;
    apply(mk(1, 0, 0, 3, 1, 0, 4'ha, 24'hdddddd, 0, 0, 0), "r_wr0");
    apply(mk(1, 0, 0, 3, 1, 1, 4'hb, 24'hdddddd, 0, 0, 0), "r_wr1");
    apply(mk(1, 0, 1, 2, 0, 0, 0, 24'hdddddd, 0, 1, 0), "r_restart");
    apply(mk(1, 1, 0, 2, 0, 0, 0, 24'haddddd, 1, 1, 0), "r_s1");
    apply(mk(1, 1, 0, 2, 0, 0, 0, 24'hbadddd, 0, 1, 0), "r_s2");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 24'hbadddd, 0, 0, 0), "len0_idle");
    apply(mk(1, 1, 0, 2, 0, 0, 0, 24'hbadddd, 0, 0, 0), "no_rearm");
    apply(mk(1, 0, 1, 31, 0, 0, 0, 24'hdddddd, 0, 1, 0), "clamp_start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
